game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- POS_MAX, 7, highest tank position; positions run 0..POS_MAX.
- T1_INIT, 0, tank1 start position.
- T2_INIT, 7, tank2 start position.
- LIFE_INIT, 3, starting life per tank (1..3).
- MOVE_LIMIT, 2, moves allowed per turn.
- SHELL_TIMEOUT, 1000, maximum FLIGHT cycles before a forced miss.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- nrst, in, 1, asynchronous active-low reset.
- btn_left, in, 1, one-cycle pulse; move current tank toward 0.
- btn_right, in, 1, one-cycle pulse; move current tank toward POS_MAX.
- btn_fire, in, 1, one-cycle pulse; advance aim/fire/restart.
- shell_done, in, 1, one-cycle pulse; shell flight finished.
- shell_hit, in, 1, sampled only with shell_done; 1 = opponent hit.
- turn, out, 1, 0 = tank1 acts, 1 = tank2 acts.
- tank1_location, out, 4, tank1 position.
- tank2_location, out, 4, tank2 position.
- tank1_life, out, 2, tank1 remaining life.
- tank2_life, out, 2, tank2 remaining life.
- charge_en, out, 1, high in CHARGE; enables power meter.
- fire, out, 1, one-cycle launch pulse to the cannon/shell path.
- game_over, out, 1, high in OVER.
- winner, out, 1, valid when game_over; 0 = tank1, 1 = tank2.
- state, out, 3, current FSM state encoding, for debug.

REQ-003 The block SHALL use the single clock clk and the asynchronous active-low reset nrst; all outputs SHALL be registered.

Function
REQ-004 States SHALL be MOVE, CHARGE, FIRE, FLIGHT, RESOLVE, SWAP, OVER.

REQ-005 MOVE:
- btn_left SHALL decrement the current tank's position; btn_right SHALL increment it.
- Each accepted move SHALL increment move_cnt.
- A move SHALL be ignored if move_cnt = MOVE_LIMIT, if the target is outside 0..POS_MAX, or if the target equals the other tank's position.
- btn_left and btn_right in the same cycle SHALL both be ignored.

REQ-006 MOVE + btn_fire -> CHARGE next cycle. If a move button arrives in the same cycle, fire wins and no move occurs.

REQ-007 CHARGE: charge_en = 1; btn_fire -> FIRE. Move buttons SHALL be ignored.

REQ-008 FIRE SHALL last exactly one cycle, with fire = 1 only in that cycle, then go to FLIGHT. The timeout counter SHALL clear on entry to FLIGHT.

REQ-009 FLIGHT:
- On shell_done, the block SHALL latch shell_hit and go to RESOLVE.
- If the counter reaches SHELL_TIMEOUT with no shell_done, the block SHALL latch a miss and go to RESOLVE.
- shell_done SHALL be ignored in every other state.

REQ-010 RESOLVE (one cycle): on a hit, the opponent's life SHALL decrement by 1, saturating at 0. If the new life = 0 -> OVER with winner = turn; otherwise -> SWAP.

REQ-011 SWAP (one cycle): turn SHALL toggle, move_cnt SHALL clear, then -> MOVE.

REQ-012 OVER:
- game_over = 1 and winner SHALL hold.
- Move buttons SHALL be ignored.
- btn_fire SHALL reload reset values (except turn = 0) and go to MOVE next cycle.

REQ-013 All button inputs in FIRE, FLIGHT, RESOLVE and SWAP SHALL be ignored and SHALL NOT be queued.

REQ-014 Position arithmetic SHALL be 4-bit with explicit bound checks; no wrap-around from 0 to POS_MAX or the reverse.

REQ-015 Latency:
- Button to location update: 1 cycle.
- btn_fire in CHARGE to fire pulse: 1 cycle.
- shell_done to life update: 2 cycles.

Reset
REQ-016 While nrst = 0, the outputs SHALL be:
- state = MOVE, turn = 0, move_cnt = 0.
- tank1_location = T1_INIT, tank2_location = T2_INIT.
- Both lives = LIFE_INIT.
- charge_en = 0, fire = 0, game_over = 0, winner = 0.

REQ-017 Reset asserted in any state, including FLIGHT mid-count, SHALL abort the operation with no fire pulse and no life change.

Verification
REQ-018 Scenario: reset, then btn_right x3 on turn 0 -> tank1_location = 2; the third press is ignored (MOVE_LIMIT = 2).

REQ-019 Scenario: tank1 at 6, tank2 at 7, btn_right -> tank1 stays at 6 (collision blocked); btn_left at position 0 -> stays at 0.

REQ-020 Scenario: btn_fire, btn_fire, then shell_done with shell_hit = 1 -> exactly one fire pulse; tank2_life 3 -> 2; turn = 1; the next cycle is MOVE.

REQ-021 Scenario: FIRE, then no shell_done -> RESOLVE entered after exactly SHELL_TIMEOUT cycles; lives unchanged; turn toggles.

REQ-022 Scenario: three tank1 hits -> tank2_life = 0, game_over = 1, winner = 0; btn_left ignored; btn_fire -> lives = 3/3, locations T1_INIT/T2_INIT, turn = 0.

REQ-023 Scenario: nrst pulsed low mid-FLIGHT -> all outputs at reset values immediately (asynchronous); a later shell_done is ignored.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Control/status bundle between the tank-game sequencer and its surroundings.
// Latency: none, wires only.
// Backpressure: none; every button and shell input is a single-cycle pulse.
interface game_sequencer_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_fire;
  logic       shell_done;
  logic       shell_hit;
  logic       turn;
  logic [3:0] tank1_location;
  logic [3:0] tank2_location;
  logic [1:0] tank1_life;
  logic [1:0] tank2_life;
  logic       charge_en;
  logic       fire;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  // Player/shell side: drives the buttons and the shell result, observes the game.
  modport master (
    output btn_left, btn_right, btn_fire, shell_done, shell_hit,
    input  turn, tank1_location, tank2_location, tank1_life, tank2_life,
    input  charge_en, fire, game_over, winner, state
  );

  // Sequencer side.
  modport slave (
    input  btn_left, btn_right, btn_fire, shell_done, shell_hit,
    output turn, tank1_location, tank2_location, tank1_life, tank2_life,
    output charge_en, fire, game_over, winner, state
  );
endinterface

// File: rtl/game_sequencer.sv
// Turn sequencer for a two-tank artillery game: move, charge, fire, await shell, score, swap.
// Latency: button to location 1 cycle; fire in CHARGE to fire pulse 1 cycle; shell_done to life 2 cycles.
// Backpressure: none; pulses arriving in states that do not accept them are dropped, never queued.
module game_sequencer #(
  parameter int POS_MAX       = 7,
  parameter int T1_INIT       = 0,
  parameter int T2_INIT       = 7,
  parameter int LIFE_INIT     = 3,
  parameter int MOVE_LIMIT    = 2,
  parameter int SHELL_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             nrst,
  game_sequencer_if.slave  gs
);

  localparam int MC_W = $clog2(MOVE_LIMIT + 1);
  localparam int TO_W = $clog2(SHELL_TIMEOUT + 1);

  localparam logic [3:0]      POS_MAX_L = 4'(POS_MAX);
  localparam logic [3:0]      T1_INIT_L = 4'(T1_INIT);
  localparam logic [3:0]      T2_INIT_L = 4'(T2_INIT);
  localparam logic [1:0]      LIFE_L    = 2'(LIFE_INIT);
  localparam logic [MC_W-1:0] MC_LIMIT  = MC_W'(MOVE_LIMIT);
  // FLIGHT counts 0..SHELL_TIMEOUT-1, so the miss is taken after exactly SHELL_TIMEOUT cycles.
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(SHELL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_MOVE    = 3'd0,
    ST_CHARGE  = 3'd1,
    ST_FIRE    = 3'd2,
    ST_FLIGHT  = 3'd3,
    ST_RESOLVE = 3'd4,
    ST_SWAP    = 3'd5,
    ST_OVER    = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic            turn_q, turn_d;
  logic [3:0]      t1_loc_q, t1_loc_d;
  logic [3:0]      t2_loc_q, t2_loc_d;
  logic [1:0]      t1_life_q, t1_life_d;
  logic [1:0]      t2_life_q, t2_life_d;
  logic [MC_W-1:0] move_cnt_q, move_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            hit_q, hit_d;
  logic            winner_q, winner_d;
  logic            charge_en_q, charge_en_d;
  logic            fire_q, fire_d;
  logic            game_over_q, game_over_d;

  logic [3:0]      cur_pos, oth_pos, tgt_pos;
  logic            move_ok;
  logic [1:0]      opp_life, new_life;

  // Evaluate a requested move of the acting tank: one direction only, in bounds, no collision, under limit.
  always_comb begin
    cur_pos = turn_q ? t2_loc_q : t1_loc_q;
    oth_pos = turn_q ? t1_loc_q : t2_loc_q;
    tgt_pos = cur_pos;
    move_ok = 1'b0;
    if (gs.btn_left && !gs.btn_right) begin
      tgt_pos = cur_pos - 4'd1;
      move_ok = (cur_pos != 4'd0);
    end else if (gs.btn_right && !gs.btn_left) begin
      tgt_pos = cur_pos + 4'd1;
      move_ok = (cur_pos < POS_MAX_L);
    end
    if ((move_cnt_q >= MC_LIMIT) || (tgt_pos == oth_pos)) begin
      move_ok = 1'b0;
    end
  end

  // Opponent life after applying the latched shell result, saturating at zero.
  always_comb begin
    opp_life = turn_q ? t1_life_q : t2_life_q;
    new_life = opp_life;
    if (hit_q && (opp_life != 2'd0)) begin
      new_life = opp_life - 2'd1;
    end
  end

  // Next-state and next-output logic for the game FSM.
  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    t1_loc_d   = t1_loc_q;
    t2_loc_d   = t2_loc_q;
    t1_life_d  = t1_life_q;
    t2_life_d  = t2_life_q;
    move_cnt_d = move_cnt_q;
    to_cnt_d   = to_cnt_q;
    hit_d      = hit_q;
    winner_d   = winner_q;

    case (state_q)
      ST_MOVE: begin
        // Fire takes priority over a move pressed in the same cycle.
        if (gs.btn_fire) begin
          state_d = ST_CHARGE;
        end else if (move_ok) begin
          if (turn_q) t2_loc_d = tgt_pos;
          else        t1_loc_d = tgt_pos;
          move_cnt_d = move_cnt_q + MC_W'(1);
        end
      end
      ST_CHARGE: begin
        if (gs.btn_fire) state_d = ST_CHARGE == ST_CHARGE ? ST_FIRE : ST_CHARGE;
      end
      ST_FIRE: begin
        to_cnt_d = '0;
        state_d  = ST_FLIGHT;
      end
      ST_FLIGHT: begin
        if (gs.shell_done) begin
          hit_d   = gs.shell_hit;
          state_d = ST_RESOLVE;
        end else if (to_cnt_q == TO_LAST) begin
          hit_d   = 1'b0;
          state_d = ST_RESOLVE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_RESOLVE: begin
        if (turn_q) t1_life_d = new_life;
        else        t2_life_d = new_life;
        if (new_life == 2'd0) begin
          winner_d = turn_q;
          state_d  = ST_OVER;
        end else begin
          state_d  = ST_SWAP;
        end
      end
      ST_SWAP: begin
        turn_d     = ~turn_q;
        move_cnt_d = '0;
        state_d    = ST_MOVE;
      end
      ST_OVER: begin
        if (gs.btn_fire) begin
          turn_d     = 1'b0;
          t1_loc_d   = T1_INIT_L;
          t2_loc_d   = T2_INIT_L;
          t1_life_d  = LIFE_L;
          t2_life_d  = LIFE_L;
          move_cnt_d = '0;
          to_cnt_d   = '0;
          hit_d      = 1'b0;
          winner_d   = 1'b0;
          state_d    = ST_MOVE;
        end
      end
      default: begin
        state_d = ST_MOVE;
      end
    endcase

    // Status flags are registered copies of the state being entered.
    charge_en_d = (state_d == ST_CHARGE);
    fire_d      = (state_d == ST_FIRE);
    game_over_d = (state_d == ST_OVER);
  end

  // State and output registers; reset aborts any turn in progress.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_MOVE;
      turn_q      <= 1'b0;
      t1_loc_q    <= T1_INIT_L;
      t2_loc_q    <= T2_INIT_L;
      t1_life_q   <= LIFE_L;
      t2_life_q   <= LIFE_L;
      move_cnt_q  <= '0;
      to_cnt_q    <= '0;
      hit_q       <= 1'b0;
      winner_q    <= 1'b0;
      charge_en_q <= 1'b0;
      fire_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      turn_q      <= turn_d;
      t1_loc_q    <= t1_loc_d;
      t2_loc_q    <= t2_loc_d;
      t1_life_q   <= t1_life_d;
      t2_life_q   <= t2_life_d;
      move_cnt_q  <= move_cnt_d;
      to_cnt_q    <= to_cnt_d;
      hit_q       <= hit_d;
      winner_q    <= winner_d;
      charge_en_q <= charge_en_d;
      fire_q      <= fire_d;
      game_over_q <= game_over_d;
    end
  end

  assign gs.turn           = turn_q;
  assign gs.tank1_location = t1_loc_q;
  assign gs.tank2_location = t2_loc_q;
  assign gs.tank1_life     = t1_life_q;
  assign gs.tank2_life     = t2_life_q;
  assign gs.charge_en      = charge_en_q;
  assign gs.fire           = fire_q;
  assign gs.game_over      = game_over_q;
  assign gs.winner         = winner_q;
  assign gs.state          = state_q;

endmodule
